// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
// uart_transmitter
//  Serialises bytes from a ready/valid producer onto a single UART line.
//  Default build sends 8N1 frames: start, 8 data bits LSB first, stop.
//  Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7 (8E1).
//  The port list and handshake are the same in both builds.
//  SYMBOL_EDGE_TIME (clk cycles per bit) must be at least 2.
module uart_transmitter #(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE      = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME    = CPU_CLOCK_FREQ / BAUD_RATE;
  localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);

  localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_CYCLE =
    CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] CYCLE_STEP =
    CLOCK_COUNTER_WIDTH'(1);
  localparam logic [2:0] LAST_DATA_BIT = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                         state;
  state_t                         state_next;
  logic [CLOCK_COUNTER_WIDTH-1:0] cycle_cnt;
  logic [CLOCK_COUNTER_WIDTH-1:0] cycle_cnt_next;
  logic [2:0]                     bit_cnt;
  logic [2:0]                     bit_cnt_next;
  logic [7:0]                     data_q;
  logic                           tx_q;
  logic                           tx_next;
  logic                           load_byte;
  logic                           symbol_done;

  // The producer may only hand over a byte while the line is idle.
  assign data_in_ready = (state == IDLE);

  // The line comes straight from a flop so it can never glitch on input changes.
  assign serial_out = tx_q;

  // The last cycle of every symbol is where the frame advances.
  assign symbol_done = (cycle_cnt == LAST_CYCLE);

  // State, counters, line flop and the latched byte; reset parks the line high in IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      bit_cnt   <= '0;
      tx_q      <= 1'b1;
      data_q    <= '0;
    end else begin
      state     <= state_next;
      cycle_cnt <= cycle_cnt_next;
      bit_cnt   <= bit_cnt_next;
      tx_q      <= tx_next;
      if (load_byte) begin
        data_q <= data_in;
      end
    end
  end

  // Next-state logic; tx_next is the level the line must show during the coming cycle.
  always_comb begin
    state_next     = state;
    cycle_cnt_next = cycle_cnt;
    bit_cnt_next   = bit_cnt;
    tx_next        = tx_q;
    load_byte      = 1'b0;

    case (state)
      IDLE: begin
        cycle_cnt_next = '0;
        bit_cnt_next   = '0;
        tx_next        = 1'b1;
        if (data_in_valid) begin
          load_byte  = 1'b1;
          state_next = START;
          tx_next    = 1'b0;
        end
      end

      START: begin
        if (symbol_done) begin
          cycle_cnt_next = '0;
          bit_cnt_next   = '0;
          state_next     = DATA;
          tx_next        = data_q[0];
        end else begin
          cycle_cnt_next = cycle_cnt + CYCLE_STEP;
        end
      end

      DATA: begin
        if (symbol_done) begin
          cycle_cnt_next = '0;
          if (bit_cnt == LAST_DATA_BIT) begin
            bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = PARITY;
            tx_next      = ^data_q;
`else
            state_next   = STOP;
            tx_next      = 1'b1;
`endif
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
            tx_next      = data_q[bit_cnt + 3'd1];
          end
        end else begin
          cycle_cnt_next = cycle_cnt + CYCLE_STEP;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (symbol_done) begin
          cycle_cnt_next = '0;
          state_next     = STOP;
          tx_next        = 1'b1;
        end else begin
          cycle_cnt_next = cycle_cnt + CYCLE_STEP;
        end
      end
`endif

      STOP: begin
        if (symbol_done) begin
          cycle_cnt_next = '0;
          state_next     = IDLE;
          tx_next        = 1'b1;
        end else begin
          cycle_cnt_next = cycle_cnt + CYCLE_STEP;
        end
      end

      default: begin
        cycle_cnt_next = '0;
        bit_cnt_next   = '0;
        state_next     = IDLE;
        tx_next        = 1'b1;
      end
    endcase
  end

endmodule
